// File: rtl/reed_solomon_decoder_pkg.sv
// Shared constants, types and helpers for the RS decoder datapath FIFOs.
package reed_solomon_decoder_pkg;

    localparam int RS_FIFO_DATA_W = 512;
    localparam int RS_FIFO_DEPTH  = 512;

    // Pointer/count width: one extra bit so a full FIFO (count == depth) is representable.
    function automatic int rs_fifo_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic not_full;
        logic not_empty;
        logic almost_full;
        logic almost_empty;
    } rs_fifo_status_t;

endpackage

// File: rtl/reed_solomon_decoder_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
// Read data follows raddr combinationally; the caller owns all flow control.
module reed_solomon_decoder_fifo_ram #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reed_solomon_decoder_fifo_v2.sv
// First-word-fall-through FIFO, one-cycle write-to-read latency; full-side enq and empty-side deq are dropped.
// Optional sticky overflow/underflow flags are built when RS_DECODER_FIFO_ERR_EN is defined.
module reed_solomon_decoder_fifo_v2
    import reed_solomon_decoder_pkg::*;
#(
    parameter int DATA_W    = RS_FIFO_DATA_W,
    parameter int DEPTH     = RS_FIFO_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        enq_data,
    input  logic                     enq_en,
    output logic                     not_full,
    output logic                     almost_full,
    output logic [DATA_W-1:0]        deq_data,
    input  logic                     deq_en,
    output logic                     not_empty,
    output logic                     almost_empty,
`ifdef RS_DECODER_FIFO_ERR_EN
    output logic                     overflow,
    output logic                     underflow,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = rs_fifo_cw(DEPTH);

    logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   free_q;
    rs_fifo_status_t status_q, status_d;
    logic            enq_acc, deq_acc;

    // Acceptance uses only this cycle's registered flags.
    assign enq_acc = enq_en & status_q.not_full;
    assign deq_acc = deq_en & status_q.not_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_acc) wr_ptr_d = wr_ptr_q + CW'(1);
            if (deq_acc) rd_ptr_d = rd_ptr_q + CW'(1);
            if (enq_acc && !deq_acc) count_d = count_q + CW'(1);
            else if (deq_acc && !enq_acc) count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        status_d.not_full     = (count_d < CW'(DEPTH));
        status_d.not_empty    = (count_d != '0);
        status_d.almost_full  = (count_d >= CW'(AF_THRESH));
        status_d.almost_empty = (count_d <= CW'(AE_THRESH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            free_q   <= CW'(DEPTH);
            status_q <= '{not_full: 1'b1, not_empty: 1'b0, almost_full: 1'b0, almost_empty: 1'b1};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            free_q   <= CW'(DEPTH) - count_d;
            status_q <= status_d;
        end
    end

`ifdef RS_DECODER_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (enq_en && !status_q.not_full)  overflow_q  <= 1'b1;
            if (deq_en && !status_q.not_empty) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    reed_solomon_decoder_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (enq_acc & ~flush),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (enq_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (deq_data)
    );

    assign count        = count_q;
    assign free         = free_q;
    assign not_full     = status_q.not_full;
    assign not_empty    = status_q.not_empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;

endmodule

// File: tb/tb_reed_solomon_decoder_fifo_v2.sv
// Directed bench for the FWFT FIFO at DATA_W=16, DEPTH=8, AF=6, AE=2.
module tb_reed_solomon_decoder_fifo_v2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] enq_data = '0;
    logic        enq_en = 1'b0;
    logic        deq_en = 1'b0;
    logic        not_full, almost_full, not_empty, almost_empty;
    logic [15:0] deq_data;
    logic [3:0]  count, free;
`ifdef RS_DECODER_FIFO_ERR_EN
    logic        overflow, underflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reed_solomon_decoder_fifo_v2 #(
        .DATA_W    (16),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .enq_data     (enq_data),
        .enq_en       (enq_en),
        .not_full     (not_full),
        .almost_full  (almost_full),
        .deq_data     (deq_data),
        .deq_en       (deq_en),
        .not_empty    (not_empty),
        .almost_empty (almost_empty),
`ifdef RS_DECODER_FIFO_ERR_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count),
        .free         (free)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        enq_en = 1'b1; enq_data = d;
        step();
        enq_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] exp);
        chk(tag, deq_data, exp);
        deq_en = 1'b1;
        step();
        deq_en = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_free"}, free, 8);
        chk({tag, "_not_empty"}, not_empty, 0);
        chk({tag, "_not_full"}, not_full, 1);
        chk({tag, "_almost_empty"}, almost_empty, 1);
        chk({tag, "_almost_full"}, almost_full, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_reset_state("rst");
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_reset_state("post_rst");

        // Fill with threshold crossings.
        for (int i = 1; i <= 8; i++) begin
            push(16'(i));
            chk("fill_count", count, 32'(i));
            chk("fill_free", free, 32'(8 - i));
            if (i == 1) chk("fill_head_latency", deq_data, 16'h0001);
            if (i == 2) chk("fill_ae_at2", almost_empty, 1);
            if (i == 3) chk("fill_ae_at3", almost_empty, 0);
            if (i == 5) chk("fill_af_at5", almost_full, 0);
            if (i == 6) chk("fill_af_at6", almost_full, 1);
            if (i == 7) chk("fill_nf_at7", not_full, 1);
        end
        chk("full_not_full", not_full, 0);
        push(16'hDEAD);
        chk("ovf_count", count, 8);
        chk("ovf_head", deq_data, 16'h0001);

        for (int i = 1; i <= 8; i++) pop_chk("drain_data", 16'(i));
        chk("drain_not_empty", not_empty, 0);
        chk("drain_count", count, 0);

        // Pointer wrap: 5 in/out, then 8 in/out crosses the storage boundary.
        for (int i = 0; i < 5; i++) push(16'h0010 + 16'(i));
        for (int i = 0; i < 5; i++) pop_chk("wrap5_data", 16'h0010 + 16'(i));
        for (int i = 0; i < 8; i++) push(16'h0020 + 16'(i));
        chk("wrap8_full", not_full, 0);
        for (int i = 0; i < 8; i++) pop_chk("wrap8_data", 16'h0020 + 16'(i));
        chk("wrap8_empty", not_empty, 0);

        // Simultaneous enq+deq while full: only the read takes effect.
        for (int i = 1; i <= 8; i++) push(16'h0030 + 16'(i));
        enq_en = 1'b1; deq_en = 1'b1; enq_data = 16'hBEEF;
        step();
        enq_en = 1'b0; deq_en = 1'b0;
        chk("full_both_count", count, 7);
        for (int i = 2; i <= 8; i++) pop_chk("full_both_data", 16'h0030 + 16'(i));
        chk("full_both_empty", not_empty, 0);

        // Simultaneous enq+deq while empty: only the write takes effect.
        enq_en = 1'b1; deq_en = 1'b1; enq_data = 16'h00AA;
        step();
        enq_en = 1'b0; deq_en = 1'b0;
        chk("empty_both_count", count, 1);
        chk("empty_both_data", deq_data, 16'h00AA);
        pop_chk("empty_both_pop", 16'h00AA);

        // Simultaneous enq+deq at count 3 keeps count.
        push(16'h00B1); push(16'h00B2); push(16'h00B3);
        enq_en = 1'b1; deq_en = 1'b1; enq_data = 16'h00B4;
        step();
        enq_en = 1'b0; deq_en = 1'b0;
        chk("mid_both_count", count, 3);
        pop_chk("mid_both_d0", 16'h00B2);
        pop_chk("mid_both_d1", 16'h00B3);
        pop_chk("mid_both_d2", 16'h00B4);

        // Flush with a concurrent write.
        for (int i = 0; i < 5; i++) push(16'h0040 + 16'(i));
        chk("pre_flush_count", count, 5);
        flush = 1'b1; enq_en = 1'b1; enq_data = 16'h0077;
        step();
        flush = 1'b0; enq_en = 1'b0;
        chk_reset_state("flush");
        push(16'h0055);
        chk("post_flush_count", count, 1);
        chk("post_flush_head", deq_data, 16'h0055);

        // Async reset between edges.
        push(16'h0056);
        chk("pre_arst_count", count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("arst");
        #1;
        reset = 1'b0;
        step();
        chk_reset_state("arst_after");

`ifdef RS_DECODER_FIFO_ERR_EN
        chk("err_ovf_init", overflow, 0);
        chk("err_udf_init", underflow, 0);
        for (int i = 0; i < 8; i++) push(16'h0060 + 16'(i));
        chk("err_ovf_before", overflow, 0);
        push(16'h0BAD);
        chk("err_ovf_set", overflow, 1);
        step();
        chk("err_ovf_sticky", overflow, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("err_ovf_flush", overflow, 0);
        deq_en = 1'b1;
        step();
        deq_en = 1'b0;
        chk("err_udf_set", underflow, 1);
        step();
        chk("err_udf_sticky", underflow, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("err_udf_flush", underflow, 0);
        chk("err_ovf_flush2", overflow, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
